blockmem_1p_pipe: RTL
=====================

# blockmem_1p_pipe

Single-port synchronous block memory with configurable read latency, read-during-write mode, optional byte-write enables, read-valid tracking and a reset-triggered clear sweep. Drop-in successor to the basic single-port block memory for datapaths that need registered outputs, known-valid read data and a memory that can be zeroed by reset without reprogramming. Sits behind AXI/register-bus memory bridges and in local scratch buffers.

## Interface

- G_DATAWIDTH, 32: data width in bits, 1..1024.
- G_MEMDEPTH, 1024: number of words; need not be a power of two.
- G_BWENABLE, 0: 1 = per-byte write enables; 0 = single write enable.
- G_RDLATENCY, 1: cycles from access to douta, 1..4.
- G_RDW_MODE, 0: read-during-write: 0 read-first, 1 write-first, 2 no-change.
- G_INIT_CLEAR, 1: 1 = rsta starts a zeroing sweep; 0 = rsta leaves contents untouched.
- G_INIT_FILE, "": hex image loaded at elaboration; empty = all zeros.
- G_ADDRWIDTH, $clog2(G_MEMDEPTH): address width.
- G_PADWIDTH, G_DATAWIDTH rounded up to a multiple of 8 (derived).
- G_WEWIDTH, G_PADWIDTH/8 if G_BWENABLE else 1 (derived).

- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  reset, synchronous, active-high.
- ena  in  1  access enable.
- wea  in  G_WEWIDTH  write enable(s); lane i covers padded bits 8i+7:8i.
- addra  in  G_ADDRWIDTH  word address.
- dina  in  G_DATAWIDTH  write data.
- douta  out  G_DATAWIDTH  read data.
- valida  out  1  douta carries the result of an access issued G_RDLATENCY cycles earlier.
- busya  out  1  clear sweep in progress; accesses ignored.

## Operation

- States: READY, CLEAR. Elaboration state READY, contents from G_INIT_FILE or zero.
- rsta high: douta=0, valida=0, all pipeline valid bits cleared (in-flight reads dropped). If G_INIT_CLEAR=1 state -> CLEAR, sweep address = 0; else state -> READY.
- CLEAR: each cycle with rsta low writes zero to sweep address, increments it; after writing G_MEMDEPTH-1, state -> READY. While rsta stays high, sweep address held at 0. busya = (state==CLEAR).
- CLEAR: ena/wea ignored, no write, no valid generated.
- READY, ena=1: access. Write when any wea bit set: enabled lanes take dina (zero-padded to G_PADWIDTH), other lanes unchanged. With G_BWENABLE=0, wea[0] enables all lanes.
- Every READY access with ena=1 issues a read of addra, except G_RDW_MODE=2 writes, which issue none.
- Read data on a write access: mode 0 = word before write; mode 1 = word after byte-merge.
- addra >= G_MEMDEPTH: write discarded; read returns 0 with valida=1.
- douta = low G_DATAWIDTH bits of padded word. Output/pipeline registers load only when their stage valid is set; douta holds its last valid value while valida=0.

## Timing

- Throughput: one access per cycle, back-to-back reads/writes allowed, no stall.
- Access at edge n -> douta/valida at edge n+G_RDLATENCY, i.e. valida high for exactly one cycle per read.
- Writes visible to a read issued the next cycle (read at n+1 returns data written at n).
- Clear sweep: G_MEMDEPTH cycles after rsta falls; busya falls after the edge writing the last address; first accepted access on the following edge.
- rsta asserted mid-sweep restarts sweep at address 0.
- Reset values: douta=0, valida=0, busya=G_INIT_CLEAR.

## Test plan

- G_MEMDEPTH=16, G_INIT_CLEAR=1: write 0xA5A5A5A5 to addr 3, pulse rsta -> busya high exactly 16 cycles, then read addr 3 returns 0 with valida after G_RDLATENCY.
- G_RDLATENCY=3: reads of addr 0..7 back-to-back after writing addr i = i*0x11 -> douta 0x00,0x11,...,0x77 on consecutive cycles, valida high 8 cycles starting 3 edges after first read.
- G_BWENABLE=1, G_DATAWIDTH=32: word 0x11223344, write dina=0xAABBCCDD wea=4'b0101 -> readback 0x11BB33DD.
- Write addr 5 old 0x1 new 0x2 per mode -> mode 0 douta=0x1, mode 1 douta=0x2, mode 2 no valida and douta unchanged.
- G_DATAWIDTH=12, G_MEMDEPTH=10: write 0xFFF to addr 12 -> no memory change; read addr 12 -> 0x000 valid; read addr 9 unaffected.
- rsta during read pipeline with G_RDLATENCY=4 -> in-flight reads never produce valida; douta=0.

Source files
------------

// File: rtl/blockmem_1p_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : blockmem_1p_pipe
//  Brief    : Single-port synchronous block memory with a configurable read
//             pipeline, read-during-write mode, optional byte enables,
//             read-valid tracking and a reset-triggered zeroing sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module blockmem_1p_pipe #(
   parameter int    G_DATAWIDTH  = 32,
   parameter int    G_MEMDEPTH   = 1024,
   parameter int    G_BWENABLE   = 0,
   parameter int    G_RDLATENCY  = 1,
   parameter int    G_RDW_MODE   = 0,
   parameter int    G_INIT_CLEAR = 1,
   parameter string G_INIT_FILE  = "",
   parameter int    G_ADDRWIDTH  = $clog2(G_MEMDEPTH),
   parameter int    G_PADWIDTH   = ((G_DATAWIDTH + 7) / 8) * 8,
   parameter int    G_WEWIDTH    = (G_BWENABLE != 0) ? G_PADWIDTH / 8 : 1
) (
   input  logic                   clka,
   input  logic                   rsta,
   input  logic                   ena,
   input  logic [G_WEWIDTH-1:0]   wea,
   input  logic [G_ADDRWIDTH-1:0] addra,
   input  logic [G_DATAWIDTH-1:0] dina,
   output logic [G_DATAWIDTH-1:0] douta,
   output logic                   valida,
   output logic                   busya
);

   localparam int                     c_NLANES    = G_PADWIDTH / 8;
   localparam logic [0:0]             c_ST_READY  = 1'b0;
   localparam logic [0:0]             c_ST_CLEAR  = 1'b1;
   localparam logic [G_ADDRWIDTH-1:0] c_LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);

   logic [G_PADWIDTH-1:0]  mem_q [0:G_MEMDEPTH-1];
   logic [0:0]             state_q, state_d;
   logic [G_ADDRWIDTH-1:0] sweep_q, sweep_d;

   logic                   w_acc;
   logic                   w_inrange;
   logic                   w_we_any;
   logic                   w_rd_issue;
   logic [c_NLANES-1:0]    w_lane_en;
   logic [G_PADWIDTH-1:0]  w_din_pad;
   logic [G_PADWIDTH-1:0]  w_old_word;
   logic [G_PADWIDTH-1:0]  w_new_word;
   logic [G_PADWIDTH-1:0]  w_rd_word;

   logic [G_RDLATENCY-1:0] vld_q;
   logic [G_DATAWIDTH-1:0] data_q [0:G_RDLATENCY-1];

   // Range check only exists when the address space exceeds the depth.
   generate
      if ((1 << G_ADDRWIDTH) > G_MEMDEPTH) begin : g_range_chk
         assign w_inrange = ({1'b0, addra} < (G_ADDRWIDTH + 1)'(G_MEMDEPTH));
      end else begin : g_range_full
         assign w_inrange = 1'b1;
      end
   endgenerate

   // Without byte enables the single write enable drives every lane.
   generate
      if (G_BWENABLE != 0) begin : g_bw
         assign w_lane_en = wea;
      end else begin : g_nobw
         assign w_lane_en = {c_NLANES{wea[0]}};
      end
   endgenerate

   assign w_we_any   = |wea;
   assign w_din_pad  = G_PADWIDTH'(dina);
   assign w_acc      = !rsta && (state_q == c_ST_READY) && ena;
   assign w_old_word = w_inrange ? mem_q[addra] : '0;
   // No-change mode suppresses the read that would accompany a write.
   assign w_rd_issue = w_acc && !((G_RDW_MODE == 2) && w_we_any);

   // Byte-lane merge of write data into the addressed word.
   always_comb begin
      w_new_word = w_old_word;
      for (int i = 0; i < c_NLANES; i++) begin
         if (w_lane_en[i]) begin
            w_new_word[8*i +: 8] = w_din_pad[8*i +: 8];
         end
      end
   end

   // Select read data: out-of-range reads return zero, write-first shows the merge.
   always_comb begin
      w_rd_word = w_old_word;
      if (!w_inrange) begin
         w_rd_word = '0;
      end else if ((G_RDW_MODE == 1) && w_we_any) begin
         w_rd_word = w_new_word;
      end
   end

   // Memory array: clear sweep has priority, accesses are ignored while clearing.
   always_ff @(posedge clka) begin
      if ((state_q == c_ST_CLEAR) && !rsta) begin
         mem_q[sweep_q] <= '0;
      end else if (w_acc && w_we_any && w_inrange) begin
         mem_q[addra] <= w_new_word;
      end
   end

   // FSM state register and sweep address.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q <= (G_INIT_CLEAR != 0) ? c_ST_CLEAR : c_ST_READY;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // FSM next state: the sweep leaves CLEAR after writing the last address.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         c_ST_CLEAR: begin
            if (sweep_q == c_LAST_ADDR) begin
               state_d = c_ST_READY;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + G_ADDRWIDTH'(1);
            end
         end
         default: begin
            state_d = c_ST_READY;
         end
      endcase
   end

   // FSM outputs.
   always_comb begin
      busya = (state_q == c_ST_CLEAR);
   end

   // Read pipeline: each stage loads data only when the incoming valid is set.
   always_ff @(posedge clka) begin
      if (rsta) begin
         vld_q <= '0;
         for (int i = 0; i < G_RDLATENCY; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= w_rd_issue;
         if (w_rd_issue) begin
            data_q[0] <= w_rd_word[G_DATAWIDTH-1:0];
         end
         for (int i = 1; i < G_RDLATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign douta  = data_q[G_RDLATENCY-1];
   assign valida = vld_q[G_RDLATENCY-1];

endmodule
`default_nettype wire
